mmu_core_req_arbiter: RTL

- Sits directly upstream of the MMU interface core port.
- Merges the instruction-fetch requester and the load/store requester into the single MMU core request channel, using a one-entry registered issue stage and round-robin arbitration.
- Tracks outstanding reads in an in-order tag FIFO and steers each MMU response, with its data and MMU flags, back to the client that issued it.

---
 rtl/mmu_core_req_arbiter_if.sv | 25 ++
 rtl/mmu_core_req_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_core_req_arbiter_if.sv
// rtl/mmu_core_req_arbiter_if.sv - MMU core request/response channel between the arbiter and the MMU interface
interface mmu_core_req_arbiter_if;
    logic        req;
    logic        lock;
    logic        data_store_ack;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rsp_req;
    logic        rsp_lock;
    logic        rsp_store_ack;
    logic [63:0] rsp_data;
    logic [23:0] rsp_flags;

    modport master (
        output req, data_store_ack, order, mask, rw, addr, data, rsp_lock,
        input  lock, rsp_req, rsp_store_ack, rsp_data, rsp_flags
    );
    modport slave (
        input  req, data_store_ack, order, mask, rw, addr, data, rsp_lock,
        output lock, rsp_req, rsp_store_ack, rsp_data, rsp_flags
    );
endinterface

// File: rtl/mmu_core_req_arbiter.sv
// rtl/mmu_core_req_arbiter.sv - fetch/ldst round-robin merge into the MMU core port with in-order read tag steering
// Optional sticky protocol checker: MIST1032ISA_MMU_ARB_PROTOCOL_CHECK_EN
module mmu_core_req_arbiter #(
    parameter int TAG_DEPTH   = 16,
    parameter int TAG_DEPTH_N = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFETCH_REQ,
    output logic        oFETCH_LOCK,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oFETCH_REQ,
    input  logic        iFETCH_LOCK,
    output logic [63:0] oFETCH_DATA,
    output logic [23:0] oFETCH_MMU_FLAGS,
    input  logic        iLDST_REQ,
    output logic        oLDST_LOCK,
    input  logic        iLDST_DATA_STORE_ACK,
    input  logic [1:0]  iLDST_ORDER,
    input  logic [3:0]  iLDST_MASK,
    input  logic        iLDST_RW,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    output logic        oLDST_REQ,
    input  logic        iLDST_LOCK,
    output logic        oLDST_STORE_ACK,
    output logic [63:0] oLDST_DATA,
    output logic [23:0] oLDST_MMU_FLAGS,
    mmu_core_req_arbiter_if.master mmu,
    output logic        oPROTOCOL_ERR
);
    logic                   valid_q, valid_d;
    logic [1:0]             order_q, order_d;
    logic [3:0]             mask_q, mask_d;
    logic                   rw_q, rw_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   sack_q, sack_d;
    logic                   tag_q, tag_d;
    logic                   rr_q, rr_d;
    logic [TAG_DEPTH-1:0]   tag_mem_q, tag_mem_d;
    logic [TAG_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_DEPTH_N:0]   count_q, count_d;

    logic grant_fetch_raw, grant_ldst_raw, winner_read;
    logic tag_full, tag_block, issue_accept, load_en;
    logic fifo_empty, fifo_full, head_tag;
    logic rsp_ack, rsp_data, rsp_fetch, rsp_ldst;
    logic tag_push, tag_pop, do_push;
    logic [TAG_DEPTH_N+1:0] reserved;

    assign grant_fetch_raw = iFETCH_REQ && (!iLDST_REQ || !rr_q);
    assign grant_ldst_raw  = iLDST_REQ && (!iFETCH_REQ || rr_q);
    assign winner_read     = grant_fetch_raw || (grant_ldst_raw && !iLDST_RW);

    // A read sitting in the issue stage already owns a tag slot, so it counts toward full.
    assign reserved     = {1'b0, count_q} + (TAG_DEPTH_N+2)'(valid_q && !rw_q);
    assign tag_full     = reserved >= (TAG_DEPTH_N+2)'(TAG_DEPTH);
    assign tag_block    = tag_full && winner_read;
    assign issue_accept = valid_q && !mmu.lock;
    assign load_en      = (!valid_q || issue_accept) && !tag_block;

    assign oFETCH_LOCK = !(load_en && grant_fetch_raw);
    assign oLDST_LOCK  = !(load_en && grant_ldst_raw);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (TAG_DEPTH_N+1)'(TAG_DEPTH));
    assign head_tag   = tag_mem_q[rd_ptr_q];

    assign rsp_ack   = mmu.rsp_req && mmu.rsp_store_ack;
    assign rsp_data  = mmu.rsp_req && !mmu.rsp_store_ack;
    assign rsp_fetch = rsp_data && !fifo_empty && !head_tag;
    assign rsp_ldst  = rsp_data && !fifo_empty && head_tag;

    assign tag_push = issue_accept && !rw_q;
    assign tag_pop  = (rsp_fetch && !iFETCH_LOCK) || (rsp_ldst && !iLDST_LOCK);
    assign do_push  = tag_push && (!fifo_full || tag_pop);

    assign oFETCH_REQ       = rsp_fetch;
    assign oFETCH_DATA      = mmu.rsp_data;
    assign oFETCH_MMU_FLAGS = mmu.rsp_flags;
    assign oLDST_REQ        = rsp_ack || rsp_ldst;
    assign oLDST_STORE_ACK  = rsp_ack;
    assign oLDST_DATA       = mmu.rsp_data;
    assign oLDST_MMU_FLAGS  = mmu.rsp_flags;

    assign mmu.req            = valid_q;
    assign mmu.data_store_ack = sack_q;
    assign mmu.order          = order_q;
    assign mmu.mask           = mask_q;
    assign mmu.rw             = rw_q;
    assign mmu.addr           = addr_q;
    assign mmu.data           = data_q;

    always_comb begin
        mmu.rsp_lock = 1'b0;
        if (rsp_ack) begin
            mmu.rsp_lock = iLDST_LOCK;
        end else if (rsp_data) begin
            if (!fifo_empty) mmu.rsp_lock = head_tag ? iLDST_LOCK : iFETCH_LOCK;
        end else begin
            mmu.rsp_lock = !fifo_empty && (iFETCH_LOCK || iLDST_LOCK);
        end
    end

    always_comb begin
        valid_d = valid_q;
        order_d = order_q;
        mask_d  = mask_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sack_d  = sack_q;
        tag_d   = tag_q;
        rr_d    = rr_q;
        if (load_en) begin
            valid_d = grant_fetch_raw || grant_ldst_raw;
            if (grant_fetch_raw) begin
                order_d = 2'h2;
                mask_d  = 4'hF;
                rw_d    = 1'b0;
                addr_d  = iFETCH_ADDR;
                data_d  = 32'h0;
                sack_d  = 1'b0;
                tag_d   = 1'b0;
                rr_d    = 1'b1;
            end else if (grant_ldst_raw) begin
                order_d = iLDST_ORDER;
                mask_d  = iLDST_MASK;
                rw_d    = iLDST_RW;
                addr_d  = iLDST_ADDR;
                data_d  = iLDST_DATA;
                sack_d  = iLDST_DATA_STORE_ACK;
                tag_d   = 1'b1;
                rr_d    = 1'b0;
            end
        end else if (issue_accept) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push) begin
            tag_mem_d[wr_ptr_q] = tag_q;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (tag_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (TAG_DEPTH_N+1)'(do_push) - (TAG_DEPTH_N+1)'(tag_pop);
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            valid_q   <= 1'b0;
            order_q   <= 2'h0;
            mask_q    <= 4'h0;
            rw_q      <= 1'b0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            sack_q    <= 1'b0;
            tag_q     <= 1'b0;
            rr_q      <= 1'b0;
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            order_q   <= order_d;
            mask_q    <= mask_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sack_q    <= sack_d;
            tag_q     <= tag_d;
            rr_q      <= rr_d;
            tag_mem_q <= tag_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

`ifdef MIST1032ISA_MMU_ARB_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (rsp_data && fifo_empty)
              | (tag_push && fifo_full)
              | (mmu.rsp_store_ack && !mmu.rsp_req);
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign oPROTOCOL_ERR = err_q;
`else
    assign oPROTOCOL_ERR = 1'b0;
`endif
endmodule
